gun_fire_ctrl: RTL
==================

Name: gun_fire_ctrl

Overview:
Shot scheduler for the player gun sprite. It takes the fire button and the gun's live vertical position, and allocates shots into N_BULLETS slots under a frame-based cooldown. Each frame it moves every live shot leftward and retires shots that leave the screen or are reported hit. It also renders the shots as a pixel layer with registered latency, in the same packed colour format as the other sprite layers, for the LCD compositor.

Parameters:
N_BULLETS, 4, number of shot slots (1..8)
MUZZLE_X, 732, spawn x (left tip of gun barrel)
MUZZLE_DY, 8, spawn y offset added to gun_pos_y
BULLET_W, 6, shot width in pixels
BULLET_H, 4, shot height in pixels
SPEED, 4, pixels moved left per frame tick
COOLDOWN, 8, frame ticks between accepted shots
BULLET_COLOR, 24'h1F3F00, packed {3'b0,R5,2'b0,G6,3'b0,B5}; default is yellow

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
lcd_xpos  in  12  current scan x
lcd_ypos  in  12  current scan y
enable  in  1  layer/game enable
freeze  in  1  pause: state held
fire  in  1  fire button level, already synchronised
gun_pos_y  in  12  gun top y (gun pos_y output)
hit_clear  in  N_BULLETS  one-cycle pulse per slot: shot hit something
bullet_pixel  out  24  shot colour or 0
pixel_valid  out  1  bullet_pixel is opaque
active_mask  out  N_BULLETS  slot live flags (registered state)
fire_ack  out  1  one-cycle pulse when a shot is spawned

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all slots inactive, x=y=0, cooldown=0, fire_q=0. Outputs bullet_pixel=0, pixel_valid=0, active_mask=0, fire_ack=0.
- frame_tick = (lcd_xpos==0 && lcd_ypos==0). It is a combinational decode of the inputs.
- Edge detect: fire_q <= fire every cycle, including during freeze and enable=0. press = fire & ~fire_q.
- Priority each cycle, highest first:
  - !enable: all slots cleared, cooldown=0, no ack.
  - freeze: slots and cooldown hold; press is dropped; hit_clear is still applied.
  - Normal operation: rules below.
- Spawn: press && cooldown==0 && any slot inactive in the registered state. Target is the lowest-index free slot.
  - Slot gets x=MUZZLE_X, y=gun_pos_y+MUZZLE_DY (12-bit, wraps, no clamp).
  - cooldown <= COOLDOWN. fire_ack=1 in the following cycle (registered).
  - A press that fails any condition is discarded, never queued.
- Cooldown: on frame_tick, if cooldown>0 and no spawn this cycle, decrement by 1.
- Move: on frame_tick, each active slot that is not spawning this cycle and not hit:
  - if x < SPEED, the slot goes inactive;
  - else x <= x-SPEED.
  - A slot spawned in the same cycle does not move until the next tick.
- hit_clear[i]: clears slot i next cycle. It wins over a move on the same cycle. It is ignored for inactive slots.
  - A slot freed by hit_clear is not available to a spawn in the same cycle, because spawn uses registered state.
- Render pipeline:
  - Stage 1 registers per-slot hit = active && enable && 0<=xpos-x<BULLET_W && 0<=ypos-y<BULLET_H. Use signed 13-bit differences.
  - Stage 2 registers pixel_valid = OR(hits) and bullet_pixel = pixel_valid ? BULLET_COLOR : 0.
  - Latency is 2 cycles from lcd_xpos/lcd_ypos to the outputs. Overlapping shots give the same colour.
- Shots spanning x=0 during a move are retired by the x<SPEED rule, never wrapped.
- active_mask mirrors slot state directly: no extra latency.

Test Plan:
- Reset, then one fire press with gun_pos_y=220 -> fire_ack pulse, active_mask=0001, slot0 x=732 y=228. Scan (732,228) -> pixel_valid=1 and bullet_pixel=24'h1F3F00 two cycles later. Scan (738,228) -> pixel_valid=0.
- Three frame ticks after the spawn -> slot0 x=720. Scan (720,231) -> valid. Scan (719,231) -> not valid.
- Press again within 8 ticks -> no ack, mask unchanged. Press after the 8th tick -> ack, mask=0011.
- Fill all 4 slots (cooldown passed each time), then a 5th press -> dropped, no ack. Pulse hit_clear=0100 -> mask=1011. Next valid press -> slot2 reused, mask=1111.
- Hold fire high across many frames -> exactly one spawn (edge detect). freeze=1 over 5 ticks -> x and cooldown unchanged. enable=0 -> mask=0000, pixel_valid=0 within 2 cycles.
- Slot at x=3 with SPEED=4 on a tick -> retired, mask bit cleared. hit_clear and frame_tick on the same cycle for the same slot -> cleared, not moved.

Source files
------------

// File: rtl/gun_fire_ctrl.sv
// Gun shot scheduler: allocates shots into slots on fire presses under a
// frame-based cooldown, moves live shots leftward each frame, retires shots
// that leave the screen or are hit, and renders them as a 2-cycle pixel layer.
module gun_fire_ctrl #(
  parameter int          N_BULLETS    = 4,
  parameter int          MUZZLE_X     = 732,
  parameter int          MUZZLE_DY    = 8,
  parameter int          BULLET_W     = 6,
  parameter int          BULLET_H     = 4,
  parameter int          SPEED        = 4,
  parameter int          COOLDOWN     = 8,
  parameter logic [23:0] BULLET_COLOR = 24'h1F3F00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          lcd_xpos,
  input  logic [11:0]          lcd_ypos,
  input  logic                 enable,
  input  logic                 freeze,
  input  logic                 fire,
  input  logic [11:0]          gun_pos_y,
  input  logic [N_BULLETS-1:0] hit_clear,
  output logic [23:0]          bullet_pixel,
  output logic                 pixel_valid,
  output logic [N_BULLETS-1:0] active_mask,
  output logic                 fire_ack
);

  localparam int                 CD_W       = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0]    CD_LOAD    = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0]    CD_ONE     = CD_W'(1);
  localparam logic [11:0]        MUZZLE_X_L = 12'(MUZZLE_X);
  localparam logic [11:0]        MUZZLE_DY_L = 12'(MUZZLE_DY);
  localparam logic [11:0]        SPEED_L    = 12'(SPEED);
  localparam logic signed [12:0] BW_S       = 13'(BULLET_W);
  localparam logic signed [12:0] BH_S       = 13'(BULLET_H);

  // Slot state
  logic [N_BULLETS-1:0] active_q, active_d;
  logic [11:0]          x_q [N_BULLETS];
  logic [11:0]          x_d [N_BULLETS];
  logic [11:0]          y_q [N_BULLETS];
  logic [11:0]          y_d [N_BULLETS];
  logic [CD_W-1:0]      cd_q, cd_d;
  logic                 fire_q;
  logic                 fire_ack_q;

  // Control decode
  logic                 frame_tick;
  logic                 press;
  logic                 any_free;
  logic                 spawn;
  logic [N_BULLETS-1:0] spawn_sel;
  logic [11:0]          spawn_y;

  // Render pipeline
  logic signed [12:0]   dx [N_BULLETS];
  logic signed [12:0]   dy [N_BULLETS];
  logic [N_BULLETS-1:0] hit_d, hit_q;
  logic                 pv_q;
  logic [23:0]          pix_q;

  assign frame_tick  = (lcd_xpos == 12'd0) && (lcd_ypos == 12'd0);
  assign press       = fire & ~fire_q;
  assign spawn_y     = gun_pos_y + MUZZLE_DY_L;
  assign active_mask = active_q;
  assign fire_ack    = fire_ack_q;
  assign pixel_valid = pv_q;
  assign bullet_pixel = pix_q;

  // Pick the lowest free slot (registered state only) and decide whether a press spawns.
  always_comb begin
    any_free  = 1'b0;
    spawn_sel = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (!active_q[i] && !any_free) begin
        spawn_sel[i] = 1'b1;
        any_free     = 1'b1;
      end
    end
    spawn = enable && !freeze && press && (cd_q == '0) && any_free;
    if (!spawn) begin
      spawn_sel = '0;
    end
  end

  // Per-slot next state: disable clears, hit beats everything else, freeze holds, then spawn or move.
  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (!enable) begin
        active_d[i] = 1'b0;
        x_d[i]      = '0;
        y_d[i]      = '0;
      end else if (hit_clear[i] && active_q[i]) begin
        active_d[i] = 1'b0;
      end else if (freeze) begin
        active_d[i] = active_q[i];
      end else if (spawn_sel[i]) begin
        active_d[i] = 1'b1;
        x_d[i]      = MUZZLE_X_L;
        y_d[i]      = spawn_y;
      end else if (frame_tick && active_q[i]) begin
        if (x_q[i] < SPEED_L) begin
          active_d[i] = 1'b0;
        end else begin
          x_d[i] = x_q[i] - SPEED_L;
        end
      end
    end
  end

  // Cooldown reloads on a spawn and otherwise counts frames down to zero.
  always_comb begin
    cd_d = cd_q;
    if (!enable) begin
      cd_d = '0;
    end else if (freeze) begin
      cd_d = cd_q;
    end else if (spawn) begin
      cd_d = CD_LOAD;
    end else if (frame_tick && (cd_q != '0)) begin
      cd_d = cd_q - CD_ONE;
    end
  end

  // Slot, cooldown, edge-detect and acknowledge registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= '0;
      cd_q       <= '0;
      fire_q     <= 1'b0;
      fire_ack_q <= 1'b0;
      for (int i = 0; i < N_BULLETS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      active_q   <= active_d;
      cd_q       <= cd_d;
      fire_q     <= fire;
      fire_ack_q <= spawn;
      for (int i = 0; i < N_BULLETS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  // Stage 1 decode: does the scan position fall inside each live shot's box.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      dx[i] = $signed({1'b0, lcd_xpos}) - $signed({1'b0, x_q[i]});
      dy[i] = $signed({1'b0, lcd_ypos}) - $signed({1'b0, y_q[i]});
      hit_d[i] = active_q[i] && enable &&
                 (dx[i] >= 13'sd0) && (dx[i] < BW_S) &&
                 (dy[i] >= 13'sd0) && (dy[i] < BH_S);
    end
  end

  // Two register stages from scan position to pixel output; overlaps share one colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= '0;
      pv_q  <= 1'b0;
      pix_q <= '0;
    end else begin
      hit_q <= hit_d;
      pv_q  <= |hit_q;
      pix_q <= (|hit_q) ? BULLET_COLOR : 24'h000000;
    end
  end

endmodule
